// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: opcodes, instruction formats,
// encoder FSM states and the opcode-to-format lookup.
package rv32i_inst_encoder_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_FENCE  = 7'h0F,
        OPC_OPIMM  = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F,
        OPC_SYSTEM = 7'h73
    } opcode_e;

    typedef enum logic [2:0] {
        OPT_R = 3'd0,
        OPT_I = 3'd1,
        OPT_S = 3'd2,
        OPT_B = 3'd3,
        OPT_U = 3'd4,
        OPT_J = 3'd5
    } optype_e;

    typedef enum logic [1:0] {
        ENC_IDLE  = 2'd0,
        ENC_PACK  = 2'd1,
        ENC_WRITE = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic    valid;
        optype_e optype;
    } optype_sel_t;

    // Unknown opcodes come back with valid cleared; the format field is then don't-care.
    function automatic optype_sel_t opcode_to_optype(input logic [6:0] opcode);
        optype_sel_t sel;
        sel.valid  = 1'b1;
        sel.optype = OPT_I;
        case (opcode_e'(opcode))
            OPC_OP:                                                      sel.optype = OPT_R;
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM:        sel.optype = OPT_I;
            OPC_STORE:                                                   sel.optype = OPT_S;
            OPC_BRANCH:                                                  sel.optype = OPT_B;
            OPC_LUI, OPC_AUIPC:                                          sel.optype = OPT_U;
            OPC_JAL:                                                     sel.optype = OPT_J;
            default: begin
                sel.valid  = 1'b0;
                sel.optype = OPT_I;
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv32i_imm_packer.sv
// Combinational packer: builds an RV32I word from decoded fields for a given format.
// RV32I_ENC_RANGE_CHECK_EN adds an immediate range/alignment error flag.
import rv32i_inst_encoder_pkg::*;

module rv32i_imm_packer (
    input  optype_e     optype_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o
);

    logic        is_shift_s;
    logic [31:0] word_s;
    logic        range_err_s;

    assign is_shift_s = (opcode_i == OPC_OPIMM) &&
                        ((funct3_i == 3'b001) || (funct3_i == 3'b101));

    // Field placement per instruction format.
    always_comb begin
        word_s = 32'h0000_0000;
        case (optype_i)
            OPT_R: word_s = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            OPT_I: begin
                if (is_shift_s) begin
                    word_s = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                end else begin
                    word_s = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                end
            end
            OPT_S: word_s = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            OPT_B: word_s = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
            OPT_U: word_s = {imm_i[31:12], rd_i, opcode_i};
            OPT_J: word_s = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: word_s = 32'h0000_0000;
        endcase
    end

`ifdef RV32I_ENC_RANGE_CHECK_EN
    logic fits12_s;
    logic fits13_s;
    logic fits21_s;

    assign fits12_s = (imm_i[31:11] == {21{imm_i[11]}});
    assign fits13_s = (imm_i[31:12] == {20{imm_i[12]}});
    assign fits21_s = (imm_i[31:20] == {12{imm_i[20]}});

    // Flag immediates that would lose information when packed.
    always_comb begin
        range_err_s = 1'b0;
        case (optype_i)
            OPT_I: begin
                if (is_shift_s) begin
                    range_err_s = |imm_i[31:5];
                end else begin
                    range_err_s = ~fits12_s;
                end
            end
            OPT_S:   range_err_s = ~fits12_s;
            OPT_B:   range_err_s = ~fits13_s | imm_i[0];
            OPT_J:   range_err_s = ~fits21_s | imm_i[0];
            OPT_U:   range_err_s = |imm_i[11:0];
            default: range_err_s = 1'b0;
        endcase
    end
`else
    assign range_err_s = 1'b0;
`endif

    assign word_o      = word_s;
    assign range_err_o = range_err_s;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// Encodes decoded RV32I fields into instruction words and writes them to IMEM
// at an auto-incrementing address. Optional macro: RV32I_ENC_RANGE_CHECK_EN.
import rv32i_inst_encoder_pkg::*;

module rv32i_inst_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err_illegal,
    output logic [15:0]       wr_count
);

    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    enc_state_e        state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [2:0]        f3_q, f3_d;
    logic [6:0]        f7_q, f7_d;
    logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]       imm_q, imm_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [15:0]       cnt_q, cnt_d;

    optype_sel_t       sel_s;
    logic [31:0]       word_s;
    logic              range_err_s;
    logic              legal_s;

    assign sel_s   = opcode_to_optype(op_q);
    assign legal_s = sel_s.valid & ~range_err_s;

    rv32i_imm_packer u_packer (
        .optype_i    (sel_s.optype),
        .opcode_i    (op_q),
        .funct3_i    (f3_q),
        .funct7_i    (f7_q),
        .rd_i        (rd_q),
        .rs1_i       (rs1_q),
        .rs2_i       (rs2_q),
        .imm_i       (imm_q),
        .word_o      (word_s),
        .range_err_o (range_err_s)
    );

    // Next-state logic; an addr_load in IDLE lands before a same-cycle request is written.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            ENC_IDLE: begin
                if (addr_load) begin
                    ptr_d = addr_value;
                end else begin
                    ptr_d = ptr_q;
                end
                if (in_valid) begin
                    op_d    = in_opcode;
                    f3_d    = in_funct3;
                    f7_d    = in_funct7;
                    rd_d    = in_rd;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    imm_d   = in_imm;
                    state_d = ENC_PACK;
                end else begin
                    state_d = ENC_IDLE;
                end
            end
            ENC_PACK: begin
                if (legal_s) begin
                    wdata_d = word_s;
                    we_d    = 1'b1;
                    state_d = ENC_WRITE;
                end else begin
                    state_d = ENC_IDLE;
                end
            end
            ENC_WRITE: begin
                if (mem_ack) begin
                    we_d    = 1'b0;
                    ptr_d   = ptr_q + PTR_ONE;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
                    state_d = ENC_IDLE;
                end else begin
                    state_d = ENC_WRITE;
                end
            end
            default: begin
                we_d    = 1'b0;
                state_d = ENC_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENC_IDLE;
            op_q    <= 7'h00;
            f3_q    <= 3'h0;
            f7_q    <= 7'h00;
            rd_q    <= 5'h00;
            rs1_q   <= 5'h00;
            rs2_q   <= 5'h00;
            imm_q   <= 32'h0000_0000;
            ptr_q   <= BASE_PTR;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == ENC_IDLE);
    assign err_illegal = (state_q == ENC_PACK) & ~legal_s;
    assign mem_we      = we_q;
    assign mem_addr    = ptr_q;
    assign mem_wdata   = wdata_q;
    assign wr_count    = cnt_q;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed-vector bench for rv32i_inst_encoder with hand-computed instruction words.
module tb_rv32i_inst_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        addr_load;
    logic [9:0]  addr_value;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        err_illegal;
    logic [15:0] wr_count;

    int n_cmp;
    int n_bad;
    int exp_ptr;
    int exp_cnt;

    rv32i_inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .addr_load   (addr_load),
        .addr_value  (addr_value),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .err_illegal (err_illegal),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm);
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    // ld_mode: 0 none, 1 addr_load with the request, 2 addr_load during PACK (ignored).
    task automatic do_write(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [31:0] exp_word, input int ack_delay,
                            input int ld_mode, input logic [9:0] ld_val);
        drive_req(op, f3, f7, rd, rs1, rs2, imm);
        if (ld_mode == 1) begin
            addr_load  = 1'b1;
            addr_value = ld_val;
            exp_ptr    = int'(ld_val);
        end
        tick();
        in_valid  = 1'b0;
        addr_load = 1'b0;
        check_eq({tag, ".pack_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, ".pack_we"}, {31'd0, mem_we}, 32'd0);
        check_eq({tag, ".pack_err"}, {31'd0, err_illegal}, 32'd0);
        if (ld_mode == 2) begin
            addr_load  = 1'b1;
            addr_value = ld_val;
        end
        tick();
        addr_load = 1'b0;
        for (int i = 0; i <= ack_delay; i++) begin
            check_eq({tag, ".we"}, {31'd0, mem_we}, 32'd1);
            check_eq({tag, ".addr"}, {22'd0, mem_addr}, exp_ptr);
            check_eq({tag, ".data"}, mem_wdata, exp_word);
            check_eq({tag, ".wr_ready"}, {31'd0, in_ready}, 32'd0);
            if (i == ack_delay) begin
                mem_ack = 1'b1;
            end
            tick();
        end
        mem_ack = 1'b0;
        exp_ptr = (exp_ptr + 1) % 1024;
        exp_cnt = exp_cnt + 1;
        check_eq({tag, ".done_we"}, {31'd0, mem_we}, 32'd0);
        check_eq({tag, ".done_ready"}, {31'd0, in_ready}, 32'd1);
        check_eq({tag, ".next_addr"}, {22'd0, mem_addr}, exp_ptr);
        check_eq({tag, ".count"}, {16'd0, wr_count}, exp_cnt);
    endtask

    task automatic do_reject(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] imm);
        drive_req(op, f3, 7'h00, 5'd1, 5'd0, 5'd0, imm);
        tick();
        in_valid = 1'b0;
        check_eq({tag, ".err"}, {31'd0, err_illegal}, 32'd1);
        check_eq({tag, ".we"}, {31'd0, mem_we}, 32'd0);
        tick();
        check_eq({tag, ".err_clr"}, {31'd0, err_illegal}, 32'd0);
        check_eq({tag, ".we_after"}, {31'd0, mem_we}, 32'd0);
        check_eq({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        check_eq({tag, ".addr"}, {22'd0, mem_addr}, exp_ptr);
        check_eq({tag, ".count"}, {16'd0, wr_count}, exp_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        exp_ptr = 0;
        exp_cnt = 0;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = 7'h00;
        in_funct3  = 3'h0;
        in_funct7  = 7'h00;
        in_rd      = 5'd0;
        in_rs1     = 5'd0;
        in_rs2     = 5'd0;
        in_imm     = 32'h0;
        addr_load  = 1'b0;
        addr_value = 10'd0;
        mem_ack    = 1'b0;
        do_reset();

        check_eq("rst.ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst.we", {31'd0, mem_we}, 32'd0);
        check_eq("rst.addr", {22'd0, mem_addr}, 32'd0);
        check_eq("rst.wdata", mem_wdata, 32'd0);
        check_eq("rst.err", {31'd0, err_illegal}, 32'd0);
        check_eq("rst.count", {16'd0, wr_count}, 32'd0);

        do_write("addi", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 0, 0, 10'd0);

        do_reset();
        do_write("sw",   7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 0, 0, 10'd0);
        do_write("lui",  7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 0, 0, 10'd0);
        do_write("beq",  7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 0, 0, 10'd0);
        do_write("jal",  7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 0, 0, 10'd0);
        do_write("add",  7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 3, 0, 10'd0);
        do_write("sub",  7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 0, 0, 10'd0);
        do_write("srai", 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3, 32'h4031_5093, 1, 0, 10'd0);

        do_reject("ill7f", 7'h7F, 3'd0, 32'd0);
`ifdef RV32I_ENC_RANGE_CHECK_EN
        do_reject("beq_odd", 7'h63, 3'd0, 32'd3);
`else
        do_write("addi_trunc", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_1005, 32'h0050_0093, 0, 0, 10'd0);
`endif

        // Reset while a write is pending drops it.
        drive_req(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("rstw.we_before", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        tick();
        check_eq("rstw.we", {31'd0, mem_we}, 32'd0);
        check_eq("rstw.addr", {22'd0, mem_addr}, 32'd0);
        check_eq("rstw.count", {16'd0, wr_count}, 32'd0);
        reset   = 1'b0;
        exp_ptr = 0;
        exp_cnt = 0;
        tick();
        check_eq("rstw.we_after", {31'd0, mem_we}, 32'd0);
        check_eq("rstw.ready", {31'd0, in_ready}, 32'd1);

        addr_load  = 1'b1;
        addr_value = 10'd1023;
        tick();
        addr_load = 1'b0;
        exp_ptr   = 1023;
        check_eq("ld.addr", {22'd0, mem_addr}, 32'd1023);
        do_write("wrap0", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 0, 0, 10'd0);
        do_write("wrap1", 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 0, 0, 10'd0);
        do_write("ldpack", 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 0, 2, 10'd5);
        do_write("ldsame", 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 0, 1, 10'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
